// File: rtl/clk_switch_ctrl.sv
// Sequencing controller for a glitch-free clock switch: registered select,
// settle window after every change, and fallback to clk0 when the PLL loses lock.
module clk_switch_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned CNT_W         = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic req_sel,
  output logic req_ready,
  input  logic pll_lock,
  output logic sel,
  output logic busy,
  output logic done,
  output logic err
);

  generate
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
      $error("SETTLE_CYCLES must be in 1..255");
    end
    if (CNT_W < $clog2(SETTLE_CYCLES + 1)) begin : g_bad_cnt_w
      $error("CNT_W too narrow for SETTLE_CYCLES");
    end
  endgenerate

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sync1_q;
  logic             lock_s_q;
  logic             sel_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic             accept_s;
  logic             lock_loss_s;

  assign req_ready   = ~busy_q & ~rst;
  assign accept_s    = req_valid & req_ready;
  // Lock loss only matters while running from clk1; a settle toward clk0 ignores lock.
  assign lock_loss_s = sel_q & ~lock_s_q;

  assign sel  = sel_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= pll_lock;
      lock_s_q <= sync1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      // Fallback wins over any request accepted on the same edge.
      if (lock_loss_s) begin
        sel_q   <= 1'b0;
        cnt_q   <= RELOAD;
        state_q <= SETTLE;
        busy_q  <= 1'b1;
        err_q   <= 1'b1;
      end else begin
        case (state_q)
          SETTLE: begin
            if (cnt_q == '0) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          IDLE: begin
            if (accept_s) begin
              if (req_sel == sel_q) begin
                done_q <= 1'b1;
              end else if (req_sel && !lock_s_q) begin
                err_q <= 1'b1;
              end else begin
                sel_q   <= req_sel;
                cnt_q   <= RELOAD;
                state_q <= SETTLE;
                busy_q  <= 1'b1;
              end
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/clk_switch_ctrl.md
CLK_SWITCH_CTRL -- requirements
Module: clk_switch_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 16, meaning the cycles `busy` is held after `sel` changes; legal range 1..255.
REQ-002 SHALL have parameter CNT_W, default 8, meaning the settle counter width; CNT_W >= $clog2(SETTLE_CYCLES+1).
REQ-003 SHALL have port clk, input, 1, the single controller clock (always-on reference clock).
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port req_valid, input, 1, switch request valid.
REQ-006 SHALL have port req_sel, input, 1, requested source: 0 = clk0 (reference), 1 = clk1 (PLL).
REQ-007 SHALL have port req_ready, output, 1, request accept; a request transfers on a clk edge with req_valid & req_ready.
REQ-008 SHALL have port pll_lock, input, 1, clk1 source locked; asynchronous to clk.
REQ-009 SHALL have port sel, output, 1, registered select driven to the glitch-free clock switch.
REQ-010 SHALL have port busy, output, 1, switch in progress.
REQ-011 SHALL have port done, output, 1, one-cycle pulse when a request or fallback completes.
REQ-012 SHALL have port err, output, 1, one-cycle pulse on a refused request or on lock loss.

Function
REQ-013 SHALL pass pll_lock through a 2-flop synchronizer (lock_s); all decisions SHALL use lock_s only.
REQ-014 SHALL implement the FSM states IDLE and SETTLE; busy SHALL be 1 exactly in SETTLE; req_ready SHALL equal !busy & !rst.
REQ-015 IDLE, accepted request with req_sel == sel: no-op; sel unchanged, stay IDLE, done=1 on the next cycle.
REQ-016 IDLE, accepted request with req_sel=1 and lock_s=0: refused; sel unchanged, stay IDLE, err=1 on the next cycle, done=0.
REQ-017 IDLE, accepted request otherwise: at the accept edge sel <= req_sel, counter <= SETTLE_CYCLES-1, go to SETTLE.
REQ-018 SETTLE: counter SHALL decrement each cycle; when the counter is 0, go to IDLE and set done=1 on that edge.
REQ-019 Net timing: sel changes at edge E; busy is high for exactly SETTLE_CYCLES cycles after E; at edge E+SETTLE_CYCLES busy=0 and done=1 for one cycle.
REQ-020 SETTLE SHALL not accept requests; req_valid held high SHALL be accepted in the first IDLE cycle.
REQ-021 Lock loss is lock_s=0 while sel=1, in either state. On lock loss: sel <= 0, counter <= SETTLE_CYCLES-1, state <= SETTLE, err=1 for one cycle; completion then follows REQ-018.
REQ-022 Lock loss SHALL take priority over a simultaneous accepted request; that request is consumed with no further effect.
REQ-023 Lock loss SHALL be reported once per event; err SHALL not repeat while sel=0.
REQ-024 During a SETTLE toward clk0, lock state SHALL be ignored and the count SHALL not restart.
REQ-025 done and err SHALL never be high in the same cycle, except on a lock-loss restart (then err=1, done=0).
REQ-026 sel SHALL be a flop output with no combinational path from any input.

Reset
REQ-027 While rst=1 at a clk edge: state=IDLE, sel=0, busy=0, done=0, err=0, counter=0, and both sync flops=0.
REQ-028 rst asserted mid-SETTLE SHALL abort the switch and force sel=0 at that edge with no done pulse.
REQ-029 In the first cycle after rst deasserts, req_ready=1 and lock_s=0 (refresh takes 2 cycles).

Verification (SETTLE_CYCLES=16)
REQ-030 Reset, then pll_lock=1 for 4 cycles, then req_sel=1 accepted at edge E -> sel=1 at E, busy high for 16 cycles, done pulses at E+16, req_ready low during busy.
REQ-031 pll_lock=0, request req_sel=1 -> err pulse next cycle, sel stays 0, busy never rises, done=0.
REQ-032 sel=1 idle, drop pll_lock -> 2 cycles later sel=0, err=1; busy high for 16 cycles; one done pulse; no further err.
REQ-033 Switching to clk1, lock drops at settle count 5 -> sel=0, count restarts at 15, a single err pulse, done 16 cycles after the fallback edge.
REQ-034 sel=0 idle, request req_sel=0 -> done pulse next cycle, busy stays 0; then rst asserted at SETTLE count 8 -> sel=0, busy=0, and no done pulse.
REQ-035 req_valid held high through SETTLE with a different req_sel -> accepted only on the first IDLE cycle after done.
